// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the program loader: image magic, FSM states,
// checksum width.
package prog_loader_pkg;

  localparam logic [7:0] MAGIC_0 = 8'h41;
  localparam logic [7:0] MAGIC_1 = 8'h53;
  localparam logic [7:0] MAGIC_2 = 8'h52;
  localparam logic [7:0] MAGIC_3 = 8'h4D;

  localparam int CHK_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_MAGIC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = MAGIC_0;
      2'd1:    magic_byte = MAGIC_1;
      2'd2:    magic_byte = MAGIC_2;
      default: magic_byte = MAGIC_3;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready byte stream from the host link into the loader.
interface prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/prog_loader_magic.sv
// Four-byte "ASRM" matcher; a mismatching 'A' restarts the match at index 1.
module prog_loader_magic
  import prog_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] byte_in,
  output logic       matched
);

  logic [1:0] idx;
  logic       hit;

  assign hit     = (byte_in == magic_byte(idx));
  assign matched = accept & hit & (idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= 2'd0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (accept) begin
      if (hit)
        idx <= idx + 2'd1;
      else
        idx <= (byte_in == MAGIC_0) ? 2'd1 : 2'd0;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a magic/length/payload/checksum image from a byte
// stream, writes the payload into program RAM and releases the CPU on success.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   ST_MAGIC   | hunting for the 4-byte magic header
//   ST_LEN_LO  | next byte is the low length byte
//   ST_LEN_HI  | next byte is the high length byte, length checked
//   ST_PAYLOAD | writing payload bytes, summing the checksum
//   ST_CHECK   | next byte is the checksum byte
//   ST_DONE    | image loaded, CPU released
//   ST_ERROR   | bad length or checksum, CPU held
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int WORD_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  prog_loader_if.slave          in_if,
  input  logic                  restart,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int MAX_LEN = 1 << ADDR_WIDTH;
  localparam int LEN_W   = ADDR_WIDTH + 1;

  state_t                 state;
  logic [LEN_W-1:0]       rem;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CHK_WIDTH-1:0]   acc;
  logic [7:0]             len_lo;
  logic [15:0]            len_full;
  logic [CHK_WIDTH-1:0]   chk_sum;
  logic                   ready;
  logic                   accept;
  logic                   magic_matched;

  assign ready = (state == ST_MAGIC)   || (state == ST_LEN_LO) ||
                 (state == ST_LEN_HI)  || (state == ST_PAYLOAD) ||
                 (state == ST_CHECK);
  assign in_if.in_ready = ready;

  // A restart in the same cycle drops the byte even though it handshook.
  assign accept   = in_if.in_valid & ready & ~restart;
  assign len_full = {in_if.in_data, len_lo};
  assign chk_sum  = acc + in_if.in_data;

  prog_loader_magic u_magic (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .accept  (accept && (state == ST_MAGIC)),
    .byte_in (in_if.in_data),
    .matched (magic_matched)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_MAGIC;
      rem         <= '0;
      addr_q      <= '0;
      acc         <= '0;
      len_lo      <= '0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      if (restart) begin
        state    <= ST_MAGIC;
        rem      <= '0;
        addr_q   <= '0;
        acc      <= '0;
        len_lo   <= '0;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
      end else if (accept) begin
        case (state)
          ST_MAGIC: begin
            if (magic_matched) state <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            len_lo <= in_if.in_data;
            state  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            addr_q <= '0;
            acc    <= '0;
            rem    <= len_full[LEN_W-1:0];
            if ({1'b0, len_full} > 17'(MAX_LEN)) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_q;
            mem_wr_data <= in_if.in_data;
            acc         <= chk_sum;
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            rem         <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (chk_sum == '0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader: the writer side of the program-memory fetch interface. It accepts an image over a valid/ready byte stream, checks a magic header, length and checksum, and writes each payload byte into the instruction RAM. It holds the CPU in reset until a complete image has loaded. It sits between the host link (UART receiver) and the write port of the program RAM that replaces the fixed ROM.

## Interface
- ADDR_WIDTH, 7, program memory address width; maximum image length is 2^ADDR_WIDTH bytes
- WORD_SIZE, 8, memory data width; must be 8
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_data  input  8  incoming image byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader can accept a byte; transfer happens when in_valid & in_ready at a clock edge
- restart  input  1  single-cycle pulse; returns the loader to MAGIC from any state
- mem_wr_en  output  1  write strobe to program RAM
- mem_addr  output  ADDR_WIDTH  write address
- mem_wr_data  output  8  write data
- cpu_hold  output  1  keeps the CPU in reset while high
- done  output  1  a valid image has been loaded
- error  output  1  load failed (bad length or bad checksum)

## Operation
- Image format, in order:
  - magic 0x41 0x53 0x52 0x4D ("ASRM")
  - LEN_LO, LEN_HI: 16-bit length, little-endian
  - LEN payload bytes
  - CHK byte, chosen so that (sum of payload + CHK) mod 256 = 0
- States:
  - MAGIC: match index 0..3. On a matching byte, index+1; after the 4th match go to LEN_LO. On a mismatch, index returns to 1 if the byte is 0x41, else to 0.
  - LEN_LO: latch the low length byte; go to LEN_HI.
  - LEN_HI: latch the high length byte.
    - LEN > 2^ADDR_WIDTH → ERROR.
    - LEN = 0 → CHECK.
    - Otherwise → PAYLOAD with address counter = 0 and checksum accumulator = 0.
  - PAYLOAD: for each accepted byte, write it at the counter address, add it to the accumulator (mod 256), and increment the counter. After byte LEN-1 go to CHECK.
  - CHECK: on the accepted byte, (acc + byte) mod 256 = 0 → DONE, otherwise → ERROR.
  - DONE: in_ready=0, done=1, cpu_hold=0.
  - ERROR: in_ready=0, error=1, cpu_hold=1.
- restart (any state) → MAGIC. It clears the counters, the accumulator, done and error, and sets cpu_hold=1. restart has priority over a byte accepted in the same cycle; that byte is dropped.
- in_ready = 1 in MAGIC, LEN_LO, LEN_HI, PAYLOAD and CHECK; it is decoded from the state.
- Memory already written before an error is not rolled back.

## Timing
- Reset values:
  - state MAGIC, so in_ready=1
  - mem_wr_en=0, mem_addr=0, mem_wr_data=0
  - cpu_hold=1, done=0, error=0
- Reset asserted mid-load aborts immediately, with no further writes.
- Write latency: a payload byte accepted at edge N gives mem_wr_en=1 with its addr/data during the cycle after N, for exactly one cycle.
  - Back-to-back bytes give back-to-back writes.
  - mem_addr/mem_wr_data hold their last value when mem_wr_en=0.
- done/error/cpu_hold are registered. They change in the cycle after the CHK byte (or offending LEN_HI byte) is accepted.
- The last payload write and the CHK acceptance may be adjacent cycles. The write completes before cpu_hold drops, because cpu_hold falls no earlier than the cycle after CHK is accepted.
- in_valid gaps of any length are tolerated; the state and counters are held.

## Structure
- Shared package (prog_loader_pkg) holds:
  - the magic byte constants
  - the state enum
  - the checksum width constant
- Optional sub-module prog_loader_magic: the 4-byte magic matcher with overlap restart. Inputs byte and accept; output matched pulse.
- Everything else (FSM, address counter, accumulator, output registers) lives in prog_loader.

## Test plan
- Nominal load: stream 41 53 52 4D 03 00 10 3D 11 A2.
  - Writes [0]=0x10, [1]=0x3D, [2]=0x11 on consecutive cycles.
  - done=1 and cpu_hold=0 one cycle after 0xA2; in_ready=0.
- Bad checksum: same stream with CHK=0xA3 → error=1, cpu_hold=1, three writes still issued; restart pulse → MAGIC with in_ready=1 and error=0.
- Length bounds (ADDR_WIDTH=7):
  - LEN 0x0081 → ERROR right after LEN_HI, no writes.
  - LEN 0x0080 with 128 bytes and a correct CHK → done, last write at address 0x7F.
  - LEN 0x0000 with CHK 0x00 → done, no writes.
- Magic overlap: stream 41 41 53 52 4D 01 00 55 AB → the load succeeds and writes [0]=0x55.
- Throttling: random in_valid gaps during payload → identical writes and result as the nominal case.
- Aborts:
  - Reset asserted after the 2nd payload byte → all outputs return to reset values; a new full image then loads correctly.
  - restart coinciding with a payload byte → the byte is dropped and not written.
